// File: rtl/dmem_arb_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dmem_arb_if
// Purpose  : Requester / data-memory bus bundle for dmem_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface dmem_arb_if #(
  parameter int SIZE = 32
);
  // Requester side, port 0 (CPU memory stage) and port 1 (accelerator)
  logic            REQ0;
  logic            REQ1;
  logic            LOCK0;
  logic            LOCK1;
  logic            WE0;
  logic            WE1;
  logic [SIZE-1:0] A0;
  logic [SIZE-1:0] A1;
  logic [SIZE-1:0] WD0;
  logic [SIZE-1:0] WD1;
  logic            GNT0;
  logic            GNT1;
  logic [SIZE-1:0] RD0;
  logic [SIZE-1:0] RD1;
  logic            RVALID0;
  logic            RVALID1;

  // Data memory side (single port, combinational read)
  logic            MEM_WE;
  logic [SIZE-1:0] MEM_A;
  logic [SIZE-1:0] MEM_WD;
  logic [SIZE-1:0] MEM_RD;

  // Environment: requesters plus the memory itself
  modport master (
    output REQ0, REQ1, LOCK0, LOCK1, WE0, WE1, A0, A1, WD0, WD1,
    input  GNT0, GNT1, RD0, RD1, RVALID0, RVALID1,
    input  MEM_WE, MEM_A, MEM_WD,
    output MEM_RD
  );

  // The arbiter
  modport slave (
    input  REQ0, REQ1, LOCK0, LOCK1, WE0, WE1, A0, A1, WD0, WD1,
    output GNT0, GNT1, RD0, RD1, RVALID0, RVALID1,
    output MEM_WE, MEM_A, MEM_WD,
    input  MEM_RD
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dmem_arbiter
// Purpose  : Two-port fixed-priority arbiter for a single-port data memory,
//            with locked bursts and registered read return.
//            Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int SIZE     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  dmem_arb_if.slave  bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_own0 = 2'd1;
  localparam logic [1:0] c_own1 = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_preempt;
  logic            w_mem_we;
  logic [SIZE-1:0] w_mem_a;
  logic [SIZE-1:0] w_mem_wd;
  logic [SIZE-1:0] r_rd0;
  logic [SIZE-1:0] r_rd1;
  logic            r_rvalid0;
  logic            r_rvalid1;

  // Grants are combinational so a dropped request never performs an access
  assign w_gnt0 = (r_state == c_own0) && bus.REQ0;
  assign w_gnt1 = (r_state == c_own1) && bus.REQ1;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int                  c_cnt_w    = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0]  c_max_wait = c_cnt_w'(MAX_WAIT);

  logic [c_cnt_w-1:0] r_wait_cnt;

  assign w_preempt = (r_state == c_own0) && bus.REQ1 && (r_wait_cnt == c_max_wait);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wait_cnt <= '0;
    end else if (!bus.REQ1 || w_gnt1 || (w_next == c_idle)) begin
      r_wait_cnt <= '0;
    end else if ((r_state == c_own0) && (r_wait_cnt != c_max_wait)) begin
      r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle: begin
        if (bus.REQ0)      w_next = c_own0;
        else if (bus.REQ1) w_next = c_own1;
        else               w_next = c_idle;
      end
      c_own0: begin
        if (w_preempt)                  w_next = c_own1;
        else if (bus.REQ0 && bus.LOCK0) w_next = c_own0;
        else if (bus.REQ1)              w_next = c_own1;
        else                            w_next = c_idle;
      end
      c_own1: begin
        if (bus.REQ1 && bus.LOCK1) w_next = c_own1;
        else if (bus.REQ0)         w_next = c_own0;
        else                       w_next = c_idle;
      end
      default: w_next = c_idle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Address/data follow the owner even without a request; only WE is qualified
  always_comb begin
    w_mem_we = 1'b0;
    w_mem_a  = '0;
    w_mem_wd = '0;
    case (r_state)
      c_own0: begin
        w_mem_we = bus.WE0 && bus.REQ0;
        w_mem_a  = bus.A0;
        w_mem_wd = bus.WD0;
      end
      c_own1: begin
        w_mem_we = bus.WE1 && bus.REQ1;
        w_mem_a  = bus.A1;
        w_mem_wd = bus.WD1;
      end
      default: begin
        w_mem_we = 1'b0;
        w_mem_a  = '0;
        w_mem_wd = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd0     <= '0;
      r_rd1     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 && !bus.WE0;
      r_rvalid1 <= w_gnt1 && !bus.WE1;
      if (w_gnt0 && !bus.WE0) begin
        r_rd0 <= bus.MEM_RD;
      end
      if (w_gnt1 && !bus.WE1) begin
        r_rd1 <= bus.MEM_RD;
      end
    end
  end

  assign bus.GNT0    = w_gnt0;
  assign bus.GNT1    = w_gnt1;
  assign bus.RD0     = r_rd0;
  assign bus.RD1     = r_rd1;
  assign bus.RVALID0 = r_rvalid0;
  assign bus.RVALID1 = r_rvalid1;
  assign bus.MEM_WE  = w_mem_we;
  assign bus.MEM_A   = w_mem_a;
  assign bus.MEM_WD  = w_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a 64-word RAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  int          vectors;
  int          miscompares;
  logic [31:0] ram [0:63];
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] bdat [0:3];
  int          g1_seen;

  dmem_arb_if #(.SIZE(32)) bus ();

  dmem_arbiter #(.SIZE(32), .MAX_WAIT(4)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.MEM_RD = ram[bus.MEM_A[5:0]];

  always @(posedge clk) begin
    if (pl_en)            ram[pl_addr] <= pl_data;
    else if (bus.MEM_WE)  ram[bus.MEM_A[5:0]] <= bus.MEM_WD;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.REQ0 = 0; bus.REQ1 = 0; bus.LOCK0 = 0; bus.LOCK1 = 0;
    bus.WE0 = 0; bus.WE1 = 0;
    bus.A0 = '0; bus.A1 = '0; bus.WD0 = '0; bus.WD1 = '0;
    bdat[0] = 32'h0000_00A0; bdat[1] = 32'h0000_00A1;
    bdat[2] = 32'h0000_00A2; bdat[3] = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    // Reset state
    chk1 ("rst_gnt0",    bus.GNT0,    1'b0);
    chk1 ("rst_gnt1",    bus.GNT1,    1'b0);
    chk1 ("rst_rvalid0", bus.RVALID0, 1'b0);
    chk1 ("rst_rvalid1", bus.RVALID1, 1'b0);
    chk32("rst_rd0",     bus.RD0,     32'h0);
    chk32("rst_rd1",     bus.RD1,     32'h0);
    chk1 ("rst_mem_we",  bus.MEM_WE,  1'b0);
    chk32("rst_mem_a",   bus.MEM_A,   32'h0);
    chk32("rst_mem_wd",  bus.MEM_WD,  32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) preload(6'(i), bdat[i]);
    preload(6'd5, 32'h5555_5555);

    // Single read, port 0
    bus.REQ0 = 1; bus.WE0 = 0; bus.A0 = 32'd3;
    #1 chk1("rd0_c0_gnt0", bus.GNT0, 1'b0);
    tick(); #1;
    chk1 ("rd0_c1_gnt0",  bus.GNT0,  1'b1);
    chk32("rd0_c1_mem_a", bus.MEM_A, 32'd3);
    chk1 ("rd0_c1_mem_we", bus.MEM_WE, 1'b0);
    tick(); bus.REQ0 = 0; #1;
    chk1 ("rd0_c2_rvalid0", bus.RVALID0, 1'b1);
    chk32("rd0_c2_rd0",     bus.RD0,     32'hDEAD_BEEF);
    chk1 ("rd0_c2_gnt0",    bus.GNT0,    1'b0);
    tick(); #1;
    chk1 ("rd0_c3_rvalid0", bus.RVALID0, 1'b0);
    chk32("rd0_c3_rd0_hold", bus.RD0,    32'hDEAD_BEEF);

    // Reset asserted in the middle of a port 0 write
    bus.REQ0 = 1; bus.WE0 = 1; bus.A0 = 32'd5; bus.WD0 = 32'h0BAD_0BAD;
    tick(); #1;
    chk1("rstw_gnt0_pre",   bus.GNT0,   1'b1);
    chk1("rstw_mem_we_pre", bus.MEM_WE, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1 ("rstw_gnt0",    bus.GNT0,    1'b0);
    chk1 ("rstw_mem_we",  bus.MEM_WE,  1'b0);
    chk1 ("rstw_rvalid0", bus.RVALID0, 1'b0);
    chk32("rstw_rd0",     bus.RD0,     32'h0);
    tick();
    bus.REQ0 = 0; bus.WE0 = 0;
    rst_n = 1'b1;
    tick(); #1;
    chk32("rstw_ram5", ram[5], 32'h5555_5555);

    // Tie from IDLE, both unlocked reads
    bus.REQ0 = 1; bus.A0 = 32'd3; bus.REQ1 = 1; bus.WE1 = 0; bus.A1 = 32'd5;
    tick(); #1;
    chk1 ("tie_c1_gnt0",  bus.GNT0,  1'b1);
    chk1 ("tie_c1_gnt1",  bus.GNT1,  1'b0);
    chk32("tie_c1_mem_a", bus.MEM_A, 32'd3);
    tick(); bus.REQ0 = 0; #1;
    chk1 ("tie_c2_gnt1",    bus.GNT1,    1'b1);
    chk1 ("tie_c2_gnt0",    bus.GNT0,    1'b0);
    chk32("tie_c2_mem_a",   bus.MEM_A,   32'd5);
    chk1 ("tie_c2_rvalid0", bus.RVALID0, 1'b1);
    tick(); bus.REQ1 = 0; #1;
    chk1 ("tie_c3_rvalid1", bus.RVALID1, 1'b1);
    chk32("tie_c3_rd1",     bus.RD1,     32'h5555_5555);
    chk1 ("tie_c3_gnt1",    bus.GNT1,    1'b0);
    tick();

    // Write then read, port 1
    bus.REQ1 = 1; bus.WE1 = 1; bus.A1 = 32'd10; bus.WD1 = 32'h1234_5678;
    tick(); #1;
    chk1 ("wr1_gnt1",   bus.GNT1,   1'b1);
    chk1 ("wr1_mem_we", bus.MEM_WE, 1'b1);
    chk32("wr1_mem_a",  bus.MEM_A,  32'd10);
    chk32("wr1_mem_wd", bus.MEM_WD, 32'h1234_5678);
    tick(); bus.REQ1 = 0; #1;
    chk1 ("wr1_no_rvalid1", bus.RVALID1, 1'b0);
    chk32("wr1_ram10",      ram[10],     32'h1234_5678);
    bus.REQ1 = 1; bus.WE1 = 0;
    tick(); #1;
    chk1("rd1_gnt1",   bus.GNT1,   1'b1);
    chk1("rd1_mem_we", bus.MEM_WE, 1'b0);
    tick(); bus.REQ1 = 0; #1;
    chk1 ("rd1_rvalid1", bus.RVALID1, 1'b1);
    chk32("rd1_rd1",     bus.RD1,     32'h1234_5678);
    tick();

    // Locked burst on port 0 against a waiting port 1
    bus.REQ0 = 1; bus.LOCK0 = 1; bus.WE0 = 0; bus.A0 = 32'd0;
    bus.REQ1 = 1; bus.WE1 = 0; bus.A1 = 32'd10;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.A0 = 32'(i);
      bus.LOCK0 = (i != 3);
      #1;
      chk1 ("burst_gnt0",  bus.GNT0,  1'b1);
      chk1 ("burst_gnt1",  bus.GNT1,  1'b0);
      chk32("burst_mem_a", bus.MEM_A, 32'(i));
      if (i > 0) begin
        chk1 ("burst_rvalid0", bus.RVALID0, 1'b1);
        chk32("burst_rd0",     bus.RD0,     bdat[i-1]);
      end
    end
    tick(); bus.REQ0 = 0; #1;
    chk1 ("burst_handoff_gnt1", bus.GNT1,    1'b1);
    chk1 ("burst_handoff_gnt0", bus.GNT0,    1'b0);
    chk1 ("burst_last_rvalid0", bus.RVALID0, 1'b1);
    chk32("burst_last_rd0",     bus.RD0,     32'hDEAD_BEEF);
    tick(); bus.REQ1 = 0; #1;
    chk1 ("burst_rvalid1", bus.RVALID1, 1'b1);
    chk32("burst_rd1",     bus.RD1,     32'h1234_5678);
    tick(); tick();

    // Port 0 holds a locked burst; port 1 requests from the first OWN0 cycle
    bus.REQ0 = 1; bus.LOCK0 = 1; bus.A0 = 32'd1;
    tick();
    bus.REQ1 = 1;
    #1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 5; k++) begin
      chk1("guard_own0_gnt0", bus.GNT0, 1'b1);
      chk1("guard_own0_gnt1", bus.GNT1, 1'b0);
      tick(); #1;
    end
    chk1("guard_preempt_gnt1", bus.GNT1, 1'b1);
    chk1("guard_preempt_gnt0", bus.GNT0, 1'b0);
`else
    g1_seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.GNT1) g1_seen++;
      tick(); #1;
    end
    chk32("starve_gnt1_count", 32'(g1_seen), 32'd0);
    chk1 ("starve_gnt0_held",  bus.GNT0,     1'b1);
`endif
    bus.REQ0 = 0; bus.LOCK0 = 0; bus.REQ1 = 0;
    tick(); tick(); #1;
    chk1("final_gnt0", bus.GNT0, 1'b0);
    chk1("final_gnt1", bus.GNT1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
